issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8: number of queue entries; legal values 2..16.
REQ-002 Parameter P_IDX_W, default 6: physical register index width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset: asynchronous, active-low.
REQ-005 rinstr_i  input  25  renamed instruction, packed from MSB: {valid, rd{valid,idx[5:0],ready}, rs1{...}, rs2{...}}, matching the rename output format.
REQ-006 wakeup_valid_i  input  1  a physical register broadcast this cycle.
REQ-007 wakeup_idx_i  input  P_IDX_W  physical index that became ready.
REQ-008 flush_i  input  1  branch mispredict: discard all queued instructions.
REQ-009 issue_ready_i  input  1  execute stage accepts an issued instruction this cycle.
REQ-010 issue_valid_o  output  1  a selected instruction is presented.
REQ-011 issue_rd_o, issue_rs1_o, issue_rs2_o  output  P_IDX_W each  physical indices of the issued instruction; an invalid field drives 0.
REQ-012 issue_rd_valid_o  output  1  the issued instruction writes rd.
REQ-013 iq_full_o  output  1  high when occupancy equals DEPTH.
REQ-014 count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow_o  output  1  one-cycle pulse when a valid insert is dropped.

Function
REQ-016 Each entry SHALL hold: valid, rd valid and idx, rs1 and rs2 idx, and per-source ready bits; an invalid source SHALL be stored as ready.
REQ-017 The queue SHALL be collapsing: slot 0 holds the oldest entry, and valid entries SHALL be contiguous from slot 0.
REQ-018 Insert: when rinstr_i.valid is high, flush_i is low and iq_full_o is low, the instruction SHALL be written at slot count minus the number issued this cycle; it becomes visible the next cycle.
REQ-019 Insert-time capture: a source whose idx equals wakeup_idx_i while wakeup_valid_i is high SHALL be stored as ready.
REQ-020 Wakeup: each stored source whose idx equals wakeup_idx_i while wakeup_valid_i is high SHALL set its ready bit on the next edge; several entries may wake on the same broadcast.
REQ-021 Select: issue_valid_o SHALL be high when any valid entry has both sources ready and flush_i is low.
REQ-022 The selected entry SHALL be the lowest-index (oldest) such entry; selection is combinational from the registered entry array.
REQ-023 A wakeup arriving in cycle N SHALL NOT make an entry selectable before cycle N+1.
REQ-024 Issue handshake: when issue_valid_o and issue_ready_i are both high, the selected entry SHALL be removed and the younger entries shifted down by one on the same edge.
REQ-025 While issue_ready_i is low, the payload MAY change if an older entry becomes ready; downstream logic SHALL sample the payload only on the handshake.
REQ-026 Full: iq_full_o SHALL be computed from registered occupancy; an insert while full SHALL be dropped even if an issue frees a slot that cycle.
REQ-027 A dropped insert SHALL pulse overflow_o for one cycle.
REQ-028 Simultaneous insert and issue SHALL leave count_o unchanged; count_o SHALL never wrap past 0 or DEPTH.
REQ-029 Flush: when flush_i is high, all entries SHALL be cleared on the next edge, an insert in the same cycle SHALL be discarded without pulsing overflow_o, and issue_valid_o SHALL be forced low.

Reset
REQ-030 Asserting rst_ni low SHALL immediately clear all entry valid bits, count_o, issue_valid_o, iq_full_o and overflow_o, including mid-operation.
REQ-031 The first insert SHALL be accepted on the first rising edge after rst_ni deasserts.

Configuration
REQ-032 Macro ISSUE_BYPASS_EN SHALL control the empty-queue bypass.
REQ-033 With ISSUE_BYPASS_EN defined: when no stored entry is selectable and rinstr_i is valid with both sources ready (after insert-time capture), it SHALL be issued in the same cycle, and it SHALL be written to the queue only if issue_ready_i is low.
REQ-034 Without ISSUE_BYPASS_EN: every instruction SHALL be written first, so the earliest issue is the cycle after insert.

Verification
REQ-035 After reset, insert rs1=p5 ready and rs2=p7 ready with issue_ready_i=1 -> without the macro, issue_valid_o=1 the next cycle with rs1=5, rs2=7 and count_o back to 0; with the macro, same-cycle issue and count_o stays 0.
REQ-036 Insert A (rs1=p40, not ready), then B (all sources ready) -> B issues first; after wakeup p40, A issues in the cycle after the wakeup.
REQ-037 Insert 8 instructions with sources not ready, then a 9th -> iq_full_o=1, overflow_o pulses, count_o=8; wakeup on a shared source -> all 8 issue oldest-first over 8 cycles.
REQ-038 Insert an instruction with rs2=p33 in the same cycle as wakeup p33, rs1 ready -> the entry is issuable the next cycle.
REQ-039 With 5 entries queued, assert flush_i together with a valid insert -> issue_valid_o=0 that cycle, count_o=0 the next cycle, and no overflow_o pulse.
REQ-040 Assert rst_ni low asynchronously with 3 entries queued -> count_o=0 and issue_valid_o=0 before the next clock edge.

Source files
------------

// File: rtl/issue_queue.sv
// Collapsing issue queue: oldest-first select, broadcast wakeup, flush.
// Ports: clk/rst_ni; rinstr_i insert; wakeup_*_i broadcast; flush_i;
//   issue_*_o/issue_ready_i handshake; iq_full_o, count_o, overflow_o.
// Optional: define ISSUE_BYPASS_EN for same-cycle empty-queue bypass.
module issue_queue #(
  parameter int DEPTH   = 8,
  parameter int P_IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic [24:0]        rinstr_i,
  input  logic               wakeup_valid_i,
  input  logic [P_IDX_W-1:0] wakeup_idx_i,
  input  logic               flush_i,
  input  logic               issue_ready_i,
  output logic               issue_valid_o,
  output logic [P_IDX_W-1:0] issue_rd_o,
  output logic [P_IDX_W-1:0] issue_rs1_o,
  output logic [P_IDX_W-1:0] issue_rs2_o,
  output logic               issue_rd_valid_o,
  output logic               iq_full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic               overflow_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic               vld;
    logic               rd_v;
    logic [P_IDX_W-1:0] rd;
    logic [P_IDX_W-1:0] rs1;
    logic               rs1_r;
    logic [P_IDX_W-1:0] rs2;
    logic               rs2_r;
  } entry_t;

  entry_t          q [DEPTH];
  entry_t          w [DEPTH];
  entry_t          d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  entry_t          n_e;
  entry_t          pick;
  entry_t          pl;
  logic            in_v;
  logic            full;
  logic            found;
  logic [DEPTH-1:0] shm;
  logic            fire;
  logic            byp;
  logic            ins_wr;
  logic [CW-1:0]   ins_pos;
  logic            unused_rd_rdy;

  assign in_v          = rinstr_i[24];
  assign unused_rd_rdy = rinstr_i[16];
  assign full          = (count_q == CW'(DEPTH));

  // Decode incoming instruction; invalid fields read as idx 0 / ready.
  always_comb begin
    n_e       = '0;
    n_e.vld   = 1'b1;
    n_e.rd_v  = rinstr_i[23];
    n_e.rd    = rinstr_i[23] ? P_IDX_W'(rinstr_i[22:17]) : '0;
    n_e.rs1   = rinstr_i[15] ? P_IDX_W'(rinstr_i[14:9]) : '0;
    n_e.rs2   = rinstr_i[7]  ? P_IDX_W'(rinstr_i[6:1])  : '0;
    n_e.rs1_r = !rinstr_i[15] || rinstr_i[8] ||
                (wakeup_valid_i && n_e.rs1 == wakeup_idx_i);
    n_e.rs2_r = !rinstr_i[7] || rinstr_i[0] ||
                (wakeup_valid_i && n_e.rs2 == wakeup_idx_i);
  end

  // Oldest ready entry; shm marks the selected slot and all above it.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    shm   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && q[i].vld && q[i].rs1_r && q[i].rs2_r) begin
        found = 1'b1;
        pick  = q[i];
      end
      shm[i] = found;
    end
  end

`ifdef ISSUE_BYPASS_EN
  assign byp = rst_ni && !found && in_v && n_e.rs1_r && n_e.rs2_r &&
               !flush_i && !full;
`else
  assign byp = 1'b0;
`endif

  assign fire    = found && !flush_i && issue_ready_i;
  assign ins_wr  = in_v && !flush_i && !full && !(byp && issue_ready_i);
  assign ins_pos = count_q - CW'(fire);
  assign ovf_d   = in_v && !flush_i && full;
  assign count_d = flush_i ? '0 :
                   count_q - CW'(fire) + CW'(ins_wr);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = q[i];
      if (wakeup_valid_i && q[i].rs1 == wakeup_idx_i)
        w[i].rs1_r = 1'b1;
      if (wakeup_valid_i && q[i].rs2 == wakeup_idx_i)
        w[i].rs2_r = 1'b1;
    end
  end

  // Collapse over the issued slot, then drop the insert on top.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++)
      d[i] = (fire && shm[i]) ? w[i+1] : w[i];
    d[DEPTH-1] = (fire && shm[DEPTH-1]) ? '0 : w[DEPTH-1];
    for (int i = 0; i < DEPTH; i++)
      if (ins_wr && ins_pos == CW'(i))
        d[i] = n_e;
    if (flush_i)
      for (int i = 0; i < DEPTH; i++)
        d[i] = '0;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= d[i];
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pl               = found ? pick : n_e;
  assign issue_valid_o    = (found || byp) && !flush_i;
  assign issue_rd_o       = pl.rd;
  assign issue_rs1_o      = pl.rs1;
  assign issue_rs2_o      = pl.rs2;
  assign issue_rd_valid_o = pl.rd_v;
  assign iq_full_o        = full;
  assign count_o          = count_q;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with an in-order expected-issue queue.
// Inputs change #1 after posedge; outputs are checked on negedge.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [24:0] rinstr_i;
  logic        wakeup_valid_i;
  logic [5:0]  wakeup_idx_i;
  logic        flush_i;
  logic        issue_ready_i;
  logic        issue_valid_o;
  logic [5:0]  issue_rd_o;
  logic [5:0]  issue_rs1_o;
  logic [5:0]  issue_rs2_o;
  logic        issue_rd_valid_o;
  logic        iq_full_o;
  logic [3:0]  count_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(8), .P_IDX_W(6)) dut (
    .clk             (clk),
    .rst_ni          (rst_ni),
    .rinstr_i        (rinstr_i),
    .wakeup_valid_i  (wakeup_valid_i),
    .wakeup_idx_i    (wakeup_idx_i),
    .flush_i         (flush_i),
    .issue_ready_i   (issue_ready_i),
    .issue_valid_o   (issue_valid_o),
    .issue_rd_o      (issue_rd_o),
    .issue_rs1_o     (issue_rs1_o),
    .issue_rs2_o     (issue_rs2_o),
    .issue_rd_valid_o(issue_rd_valid_o),
    .iq_full_o       (iq_full_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  function automatic logic [24:0] mk(
    input logic [5:0] rd,
    input logic [5:0] s1, input logic r1,
    input logic [5:0] s2, input logic r2);
    return {1'b1, 1'b1, rd, 1'b0, 1'b1, s1, r1, 1'b1, s2, r2};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int rd, input int s1, input int s2);
    exp_q.push_back({6'(rd), 6'(s1), 6'(s2)});
  endtask

  task automatic expect_issue(input string tag);
    logic [17:0] e;
    chk({tag, "_valid"}, 32'(issue_valid_o), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed issue expected empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'({issue_rd_o, issue_rs1_o, issue_rs2_o}), 32'(e));
      chk({tag, "_rdv"}, 32'(issue_rd_valid_o), 32'd1);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni         = 1'b0;
    rinstr_i       = '0;
    wakeup_valid_i = 1'b0;
    wakeup_idx_i   = '0;
    flush_i        = 1'b0;
    issue_ready_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(issue_valid_o), 32'd0);
    chk("rst_full", 32'(iq_full_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    rst_ni = 1'b1;
    nxt();

    // Insert then issue next cycle; insert+issue keeps count.
    issue_ready_i = 1'b1;
    rinstr_i = mk(1, 5, 1, 7, 1);
    push(1, 5, 7);
    @(negedge clk);
    chk("t1_noissue", 32'(issue_valid_o), 32'd0);
    chk("t1_cnt0", 32'(count_o), 32'd0);
    nxt();
    rinstr_i = mk(5, 12, 1, 13, 1);
    push(5, 12, 13);
    @(negedge clk);
    expect_issue("t1_a");
    chk("t1_cnt1", 32'(count_o), 32'd1);
    nxt();
    rinstr_i = '0;
    @(negedge clk);
    chk("t1_cnt_same", 32'(count_o), 32'd1);
    expect_issue("t1_b");
    nxt();
    @(negedge clk);
    chk("t1_cnt_end", 32'(count_o), 32'd0);
    chk("t1_idle", 32'(issue_valid_o), 32'd0);
    nxt();

    // Younger ready entry passes an older waiting one.
    rinstr_i = mk(2, 40, 0, 7, 1);
    nxt();
    rinstr_i = mk(3, 8, 1, 9, 1);
    push(3, 8, 9);
    @(negedge clk);
    chk("t2_a_wait", 32'(issue_valid_o), 32'd0);
    nxt();
    rinstr_i = '0;
    @(negedge clk);
    expect_issue("t2_b");
    nxt();
    wakeup_valid_i = 1'b1;
    wakeup_idx_i   = 6'd40;
    @(negedge clk);
    chk("t2_wake_late", 32'(issue_valid_o), 32'd0);
    chk("t2_cnt", 32'(count_o), 32'd1);
    nxt();
    wakeup_valid_i = 1'b0;
    push(2, 40, 7);
    @(negedge clk);
    expect_issue("t2_a");
    nxt();

    // Fill, overflow, then drain oldest-first on a shared wakeup.
    issue_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rinstr_i = mk(6'(10 + i), 50, 0, 6'(20 + i), 1);
      nxt();
    end
    rinstr_i = mk(30, 50, 0, 21, 1);
    @(negedge clk);
    chk("t3_full", 32'(iq_full_o), 32'd1);
    chk("t3_cnt8", 32'(count_o), 32'd8);
    chk("t3_ovf_pre", 32'(overflow_o), 32'd0);
    nxt();
    rinstr_i = '0;
    @(negedge clk);
    chk("t3_ovf", 32'(overflow_o), 32'd1);
    chk("t3_cnt_hold", 32'(count_o), 32'd8);
    nxt();
    issue_ready_i  = 1'b1;
    wakeup_valid_i = 1'b1;
    wakeup_idx_i   = 6'd50;
    @(negedge clk);
    chk("t3_ovf_clr", 32'(overflow_o), 32'd0);
    chk("t3_wake_late", 32'(issue_valid_o), 32'd0);
    nxt();
    wakeup_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(10 + i, 50, 20 + i);
      @(negedge clk);
      expect_issue($sformatf("t3_drain%0d", i));
      nxt();
    end
    @(negedge clk);
    chk("t3_empty", 32'(count_o), 32'd0);
    chk("t3_notfull", 32'(iq_full_o), 32'd0);
    nxt();

    // Insert-time capture of a same-cycle wakeup.
    rinstr_i       = mk(4, 11, 1, 33, 0);
    wakeup_valid_i = 1'b1;
    wakeup_idx_i   = 6'd33;
    @(negedge clk);
    chk("t4_noissue", 32'(issue_valid_o), 32'd0);
    nxt();
    rinstr_i       = '0;
    wakeup_valid_i = 1'b0;
    push(4, 11, 33);
    @(negedge clk);
    expect_issue("t4_cap");
    nxt();

    // Flush with a concurrent insert.
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rinstr_i = mk(6'(40 + i), 60, 0, 61, 1);
      nxt();
    end
    rinstr_i = mk(45, 1, 1, 2, 1);
    nxt();
    rinstr_i = '0;
    @(negedge clk);
    chk("t5_cnt5", 32'(count_o), 32'd5);
    chk("t5_ready", 32'(issue_valid_o), 32'd1);
    chk("t5_rd", 32'(issue_rd_o), 32'd45);
    nxt();
    flush_i  = 1'b1;
    rinstr_i = mk(46, 3, 1, 4, 1);
    @(negedge clk);
    chk("t5_flush_v", 32'(issue_valid_o), 32'd0);
    nxt();
    flush_i  = 1'b0;
    rinstr_i = '0;
    @(negedge clk);
    chk("t5_cnt0", 32'(count_o), 32'd0);
    chk("t5_no_ovf", 32'(overflow_o), 32'd0);
    chk("t5_idle", 32'(issue_valid_o), 32'd0);
    nxt();

    // Asynchronous reset mid-operation, then first insert.
    rinstr_i = mk(1, 62, 0, 2, 1);
    nxt();
    rinstr_i = mk(2, 62, 0, 2, 1);
    nxt();
    rinstr_i = mk(3, 4, 1, 5, 1);
    nxt();
    rinstr_i = '0;
    @(negedge clk);
    chk("t6_cnt3", 32'(count_o), 32'd3);
    chk("t6_ready", 32'(issue_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_async_cnt", 32'(count_o), 32'd0);
    chk("t6_async_v", 32'(issue_valid_o), 32'd0);
    chk("t6_async_full", 32'(iq_full_o), 32'd0);
    @(negedge clk);
    rst_ni        = 1'b1;
    issue_ready_i = 1'b1;
    rinstr_i      = mk(7, 8, 1, 9, 1);
    push(7, 8, 9);
    nxt();
    rinstr_i = '0;
    @(negedge clk);
    chk("t6_first_cnt", 32'(count_o), 32'd1);
    expect_issue("t6_first");
    nxt();
    @(negedge clk);
    chk("t6_end_cnt", 32'(count_o), 32'd0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_left: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
